// File: rtl/dma_dreq_frontend_pkg.sv
// Shared definitions for the DMA DREQ front end.
// Optional glitch filter is selected with DMA_DREQ_FILTER_EN (see dma_dreq_chan).
package dma_pkg;

  localparam int unsigned NUM_CH_DEF = 4;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_PENDING,
    CH_SERVICE
  } chan_state_t;

endpackage

// File: rtl/dma_dreq_frontend_if.sv
// Request/acknowledge bundle between peripherals, controller and the DREQ front end.
// master: drives requests, sense bits, DACK, mode and overrun clear; slave: the front end.
interface dma_dreq_frontend_if
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF
);

  logic [NUM_CH-1:0] dreq_in;
  logic              dreq_sense_low;
  logic [NUM_CH-1:0] dack;
  logic              dack_sense_hi;
  logic [NUM_CH-1:0] edge_mode;
  logic [NUM_CH-1:0] ovr_clr;
  logic [NUM_CH-1:0] dreq_out;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] overrun;

  modport master (
    output dreq_in, dreq_sense_low, dack, dack_sense_hi, edge_mode, ovr_clr,
    input  dreq_out, pending, overrun
  );

  modport slave (
    input  dreq_in, dreq_sense_low, dack, dack_sense_hi, edge_mode, ovr_clr,
    output dreq_out, pending, overrun
  );

endinterface

// File: rtl/dma_dreq_frontend_chan.sv
// One DREQ channel: synchronizer, polarity fold, optional glitch filter
// (DMA_DREQ_FILTER_EN) and the level/edge request FSM with registered outputs.
module dma_dreq_chan
  import dma_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
`ifdef DMA_DREQ_FILTER_EN
  ,
  parameter int unsigned FILTER_CYCLES = 3
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic dreqRaw,
  input  logic dreqSenseLow,
  input  logic dackAct,
  input  logic edgeMode,
  input  logic ovrClr,
  output logic dreqOut,
  output logic pending,
  output logic overrun
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   normLvl;
  logic                   req;
  logic                   reqPrev;
  logic                   reqEdge;
  logic                   modePrev;
  logic                   rearm;
  chan_state_t            state;

  // Synchronizer chain; resets to the raw level that means "inactive"
  always_ff @(posedge clk) begin
    if (rst) begin
      syncQ <= {SYNC_STAGES{dreqSenseLow}};
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], dreqRaw};
    end
  end

  assign normLvl = syncQ[SYNC_STAGES-1] ^ dreqSenseLow;

`ifdef DMA_DREQ_FILTER_EN
  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);

  logic [CntW-1:0] fltCnt;
  logic            fltLvl;

  // Accept a new level only after FILTER_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      fltCnt <= '0;
      fltLvl <= 1'b0;
    end else if (normLvl == fltLvl) begin
      fltCnt <= '0;
    end else if (fltCnt == CntW'(FILTER_CYCLES - 1)) begin
      fltLvl <= normLvl;
      fltCnt <= '0;
    end else begin
      fltCnt <= fltCnt + 1'b1;
    end
  end

  assign req = fltLvl;
`else
  assign req = normLvl;
`endif

  assign reqEdge = req & ~reqPrev;

  // Request FSM; overrun default clears on ovrClr, later set assignments win
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CH_IDLE;
      rearm    <= 1'b0;
      dreqOut  <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      reqPrev  <= 1'b0;
      modePrev <= edgeMode;
    end else begin
      reqPrev  <= req;
      modePrev <= edgeMode;
      overrun  <= overrun & ~ovrClr;
      if (edgeMode != modePrev) begin
        state   <= CH_IDLE;
        rearm   <= 1'b0;
        pending <= 1'b0;
        dreqOut <= edgeMode ? 1'b0 : req;
      end else if (!edgeMode) begin
        state   <= CH_IDLE;
        rearm   <= 1'b0;
        pending <= 1'b0;
        dreqOut <= req;
      end else begin
        unique case (state)
          CH_IDLE: begin
            if (reqEdge) begin
              state   <= CH_PENDING;
              dreqOut <= 1'b1;
              pending <= 1'b1;
            end
          end
          CH_PENDING: begin
            if (reqEdge) overrun <= 1'b1;
            if (dackAct) begin
              state   <= CH_SERVICE;
              dreqOut <= 1'b0;
              pending <= 1'b0;
            end
          end
          CH_SERVICE: begin
            if (reqEdge && rearm) overrun <= 1'b1;
            if (!dackAct) begin
              rearm <= 1'b0;
              if (rearm || reqEdge) begin
                state   <= CH_PENDING;
                dreqOut <= 1'b1;
                pending <= 1'b1;
              end else begin
                state   <= CH_IDLE;
                pending <= 1'b0;
              end
            end else if (reqEdge) begin
              rearm   <= 1'b1;
              pending <= 1'b1;
            end
          end
          default: begin
            state   <= CH_IDLE;
            rearm   <= 1'b0;
            dreqOut <= 1'b0;
            pending <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/dma_dreq_frontend.sv
// DREQ front end top: DACK polarity fold and per-channel instances.
// Define DMA_DREQ_FILTER_EN to enable the per-channel glitch filter.
module dma_dreq_frontend
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH        = NUM_CH_DEF,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3
) (
  input logic                CLK,
  input logic                RESET,
  dma_dreq_frontend_if.slave bus
);

  localparam bit CfgOk = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 3) && (FILTER_CYCLES >= 1);

  logic [NUM_CH-1:0] dackAct;

  assign dackAct = ~(bus.dack ^ {NUM_CH{bus.dack_sense_hi}});

  cfgLegal: assert property (@(posedge CLK) CfgOk);

  for (genvar i = 0; i < NUM_CH; i++) begin : gChan
    dma_dreq_chan #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef DMA_DREQ_FILTER_EN
      ,
      .FILTER_CYCLES(FILTER_CYCLES)
`endif
    ) uChan (
      .clk         (CLK),
      .rst         (RESET),
      .dreqRaw     (bus.dreq_in[i]),
      .dreqSenseLow(bus.dreq_sense_low),
      .dackAct     (dackAct[i]),
      .edgeMode    (bus.edge_mode[i]),
      .ovrClr      (bus.ovr_clr[i]),
      .dreqOut     (bus.dreq_out[i]),
      .pending     (bus.pending[i]),
      .overrun     (bus.overrun[i])
    );
  end

endmodule

// File: tb/tb_dma_dreq_frontend.sv
// Self-checking bench for dma_dreq_frontend: directed scenarios plus randomized
// traffic, all outputs compared every cycle against a behavioural model.
module tb_dma_dreq_frontend;
  import dma_pkg::*;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned FC   = 3;
`ifdef DMA_DREQ_FILTER_EN
  localparam int unsigned LAT = SYNC + FC + 1;
`else
  localparam int unsigned LAT = SYNC + 1;
`endif

  logic CLK;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  dma_dreq_frontend_if #(.NUM_CH(NCH)) bus ();

  dma_dreq_frontend #(
    .NUM_CH       (NCH),
    .SYNC_STAGES  (SYNC),
    .FILTER_CYCLES(FC)
  ) dut (
    .CLK  (CLK),
    .RESET(rst),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state: request delay line, filter window, per-channel request bookkeeping
  logic [NCH-1:0] normHist[$];
  logic [NCH-1:0] fltWin[$];
  logic [NCH-1:0] fltLvlM;
  logic [NCH-1:0] lastReq;
  logic [NCH-1:0] waiting;
  logic [NCH-1:0] serving;
  logic [NCH-1:0] rearmM;
  logic [NCH-1:0] ovrM;
  logic [NCH-1:0] modePrevM;
  logic [NCH-1:0] expDreq;
  logic [NCH-1:0] expPend;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelEdge();
    logic [NCH-1:0] reqNow;
    logic [NCH-1:0] reqUse;
    logic [NCH-1:0] dackActM;
    logic           ev;
    if (rst) begin
      normHist.delete();
      for (int unsigned k = 0; k < SYNC; k++) normHist.push_back('0);
      fltWin.delete();
      for (int unsigned k = 0; k < FC; k++) fltWin.push_back('0);
      fltLvlM   = '0;
      lastReq   = '0;
      waiting   = '0;
      serving   = '0;
      rearmM    = '0;
      ovrM      = '0;
      modePrevM = bus.edge_mode;
      expDreq   = '0;
      expPend   = '0;
    end else begin
      reqNow = normHist.pop_front();
      normHist.push_back(bus.dreq_in ^ {NCH{bus.dreq_sense_low}});
`ifdef DMA_DREQ_FILTER_EN
      reqUse = fltLvlM;
      void'(fltWin.pop_front());
      fltWin.push_back(reqNow);
      for (int unsigned c = 0; c < NCH; c++) begin
        bit allDiff;
        allDiff = 1'b1;
        foreach (fltWin[k]) if (fltWin[k][c] == fltLvlM[c]) allDiff = 1'b0;
        if (allDiff) fltLvlM[c] = reqNow[c];
      end
`else
      reqUse = reqNow;
`endif
      dackActM = ~(bus.dack ^ {NCH{bus.dack_sense_hi}});
      for (int unsigned c = 0; c < NCH; c++) begin
        ev = reqUse[c] & ~lastReq[c];
        ovrM[c] = ovrM[c] & ~bus.ovr_clr[c];
        if (bus.edge_mode[c] != modePrevM[c] || !bus.edge_mode[c]) begin
          waiting[c] = 1'b0;
          serving[c] = 1'b0;
          rearmM[c]  = 1'b0;
          expDreq[c] = bus.edge_mode[c] ? 1'b0 : reqUse[c];
        end else begin
          if (waiting[c]) begin
            if (ev) ovrM[c] = 1'b1;
            if (dackActM[c]) begin
              waiting[c] = 1'b0;
              serving[c] = 1'b1;
            end
          end else if (serving[c]) begin
            if (ev && rearmM[c]) ovrM[c] = 1'b1;
            if (!dackActM[c]) begin
              serving[c] = 1'b0;
              waiting[c] = rearmM[c] | ev;
              rearmM[c]  = 1'b0;
            end else if (ev) begin
              rearmM[c] = 1'b1;
            end
          end else if (ev) begin
            waiting[c] = 1'b1;
          end
          expDreq[c] = waiting[c];
        end
        expPend[c]   = waiting[c] | (serving[c] & rearmM[c]);
        lastReq[c]   = reqUse[c];
        modePrevM[c] = bus.edge_mode[c];
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    modelEdge();
    #1;
    checkEq("dreqOut", 32'(bus.dreq_out), 32'(expDreq));
    checkEq("pending", 32'(bus.pending), 32'(expPend));
    checkEq("overrun", 32'(bus.overrun), 32'(ovrM));
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick();
  endtask

  task automatic waitOut(input int unsigned ch, input logic lvl, output int unsigned n);
    n = 0;
    for (int unsigned k = 1; k <= 40; k++) begin
      tick();
      if (bus.dreq_out[ch] == lvl) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pulse(input int unsigned ch);
    bus.dreq_in[ch] = ~bus.dreq_sense_low;
    ticks(4);
    bus.dreq_in[ch] = bus.dreq_sense_low;
    ticks(4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic        saw;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.dreq_in        = 4'hF;
    bus.dreq_sense_low = 1'b0;
    bus.dack           = '0;
    bus.dack_sense_hi  = 1'b1;
    bus.edge_mode      = '0;
    bus.ovr_clr        = '0;

    // Reset held three cycles with all requests active
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      checkEq("rstDreq", 32'(bus.dreq_out), 32'h0);
      checkEq("rstPend", 32'(bus.pending), 32'h0);
      checkEq("rstOvr", 32'(bus.overrun), 32'h0);
    end
    rst = 1'b0;
    tick();
    checkEq("rstDreqAfter", 32'(bus.dreq_out), 32'h0);
    bus.dreq_in = '0;
    ticks(10);

    // Level-mode latency on channel 0
    bus.dreq_in[0] = 1'b1;
    waitOut(0, 1'b1, n);
    checkEq("lvlRiseLat", n, LAT);
    bus.dreq_in[0] = 1'b0;
    waitOut(0, 1'b0, n);
    checkEq("lvlFallLat", n, LAT);

    // Edge latch on channel 2
    bus.edge_mode[2] = 1'b1;
    ticks(2);
    pulse(2);
    ticks(LAT);
    checkEq("edgeLatch", 32'(bus.dreq_out[2]), 32'h1);
    ticks(5);
    checkEq("edgeHold", 32'(bus.dreq_out[2]), 32'h1);
    bus.dack[2] = 1'b1;
    tick();
    checkEq("ackDrop", 32'(bus.dreq_out[2]), 32'h0);
    tick();
    bus.dack[2] = 1'b0;
    tick();
    checkEq("ackIdleOut", 32'(bus.dreq_out[2]), 32'h0);
    checkEq("ackIdlePend", 32'(bus.pending[2]), 32'h0);

    // Overrun on channel 1, clear, and clear colliding with a new overrun
    bus.edge_mode[1] = 1'b1;
    ticks(2);
    pulse(1);
    pulse(1);
    ticks(LAT + 2);
    checkEq("ovrTwoEdges", 32'(bus.overrun[1]), 32'h1);
    bus.ovr_clr[1] = 1'b1;
    tick();
    bus.ovr_clr[1] = 1'b0;
    tick();
    checkEq("ovrClr", 32'(bus.overrun[1]), 32'h0);
    bus.dreq_in[1] = 1'b1;
    tick();
    ticks(LAT - 2);
    bus.ovr_clr[1] = 1'b1;
    tick();
    bus.ovr_clr[1] = 1'b0;
    checkEq("ovrSetWins", 32'(bus.overrun[1]), 32'h1);
    bus.dreq_in[1] = 1'b0;
    ticks(4);
    bus.dack[1] = 1'b1;
    ticks(2);
    bus.dack[1] = 1'b0;
    ticks(2);

    // Re-arm on channel 3 while in service
    bus.edge_mode[3] = 1'b1;
    ticks(2);
    pulse(3);
    checkEq("armPend", 32'(bus.pending[3]), 32'h1);
    bus.dack[3] = 1'b1;
    ticks(2);
    pulse(3);
    ticks(LAT);
    checkEq("rearmPend", 32'(bus.pending[3]), 32'h1);
    checkEq("svcOut", 32'(bus.dreq_out[3]), 32'h0);
    bus.dack[3] = 1'b0;
    tick();
    checkEq("rearmOut", 32'(bus.dreq_out[3]), 32'h1);
    checkEq("rearmPendKeep", 32'(bus.pending[3]), 32'h1);
    bus.dack[3] = 1'b1;
    ticks(2);
    bus.dack[3] = 1'b0;
    ticks(2);

    // Active-low requests in level mode
    bus.edge_mode      = '0;
    bus.dreq_sense_low = 1'b1;
    bus.dreq_in        = 4'hF;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(6);
`ifdef DMA_DREQ_FILTER_EN
    bus.dreq_in[0] = 1'b0;
    ticks(2);
    bus.dreq_in[0] = 1'b1;
    saw = 1'b0;
    for (int unsigned k = 0; k < 12; k++) begin
      tick();
      saw = saw | bus.dreq_out[0];
    end
    checkEq("glitchBlocked", 32'(saw), 32'h0);
`else
    saw = 1'b0;
`endif
    bus.dreq_in[0] = 1'b0;
    waitOut(0, 1'b1, n);
    checkEq("lowPulseLat", n, LAT);
    bus.dreq_in[0] = 1'b1;
    waitOut(0, 1'b0, n);
    checkEq("lowReleaseLat", n, LAT);

    // Randomized traffic, each phase with fresh sense settings applied under reset
    for (int unsigned p = 0; p < 4; p++) begin
      bus.dreq_sense_low = 1'($urandom_range(0, 1));
      bus.dack_sense_hi  = 1'($urandom_range(0, 1));
      bus.dreq_in        = {NCH{bus.dreq_sense_low}};
      bus.dack           = {NCH{~bus.dack_sense_hi}};
      bus.edge_mode      = NCH'($urandom);
      bus.ovr_clr        = '0;
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      for (int unsigned k = 0; k < 700; k++) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 5) == 0) bus.dreq_in[c] = ~bus.dreq_in[c];
          if ($urandom_range(0, 4) == 0) bus.dack[c] = ~bus.dack[c];
          if ($urandom_range(0, 149) == 0) bus.edge_mode[c] = ~bus.edge_mode[c];
          bus.ovr_clr[c] = ($urandom_range(0, 19) == 0);
        end
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
